// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: transfer-engine modes, FSM encoding and the
// CPU memory map.
package chip8_pkg;

   localparam logic [1:0] XFER_COPY = 2'd0;
   localparam logic [1:0] XFER_FILL = 2'd1;
   localparam logic [1:0] XFER_XOR  = 2'd2;

   typedef enum logic [2:0] {
      XS_IDLE,
      XS_RD_SRC,
      XS_RD_DST,
      XS_WR,
      XS_DONE
   } xfer_state_e;

   localparam logic [11:0] STACK_BASE  = 12'h000;
   localparam logic [11:0] REG_BASE    = 12'h020;
   localparam logic [11:0] SCREEN_BASE = 12'h100;

   // The reserved mode code behaves as FILL.
   function automatic logic [1:0] xfer_mode_norm(input logic [1:0] m);
      return (m == 2'd3) ? XFER_FILL : m;
   endfunction

endpackage

// File: rtl/mem_xfer_engine.sv
// Block-transfer engine (COPY / FILL / XOR-blit with collision) driving the
// shared CHIP-8 memory port with the core's request/ack read protocol.
module mem_xfer_engine
   import chip8_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              collision,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_ack,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data
);

   xfer_state_e       state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] sbuf_q, sbuf_d;
   logic [DATA_W-1:0] dbuf_q, dbuf_d;
   logic              coll_q, coll_d;

   logic [ADDR_W-1:0] src_elem;
   logic [ADDR_W-1:0] dst_elem;
   logic [DATA_W-1:0] wr_data;
   logic              last_elem;

   assign src_elem  = src_q + ADDR_W'(idx_q);
   assign dst_elem  = dst_q + ADDR_W'(idx_q);
   // Compare before increment so count = all-ones never wraps the index.
   assign last_elem = (idx_q == cnt_q);
   assign collision = coll_q;

   // The request stays up until the ack cycle, where it drops combinationally.
   function automatic logic rd_req(input logic ack);
      return ~ack;
   endfunction

   always_comb begin
      wr_data = fill_q;
      case (mode_q)
         XFER_COPY: wr_data = sbuf_q;
         XFER_XOR:  wr_data = sbuf_q ^ dbuf_q;
         default:   wr_data = fill_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      fill_d      = fill_q;
      sbuf_d      = sbuf_q;
      dbuf_d      = dbuf_q;
      coll_d      = coll_q;
      busy        = 1'b0;
      done        = 1'b0;
      mem_rd      = 1'b0;
      mem_rd_addr = '0;
      mem_wr      = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;

      unique case (state_q)
         XS_IDLE: begin
            // Abort is meaningless here, so a simultaneous start simply wins.
            if (start) begin
               mode_d  = xfer_mode_norm(mode);
               src_d   = src_addr;
               dst_d   = dst_addr;
               cnt_d   = count;
               fill_d  = fill_value;
               idx_d   = '0;
               coll_d  = 1'b0;
               state_d = (xfer_mode_norm(mode) == XFER_FILL) ? XS_WR : XS_RD_SRC;
            end
         end
         XS_RD_SRC: begin
            busy        = 1'b1;
            mem_rd      = rd_req(mem_rd_ack);
            mem_rd_addr = src_elem;
            if (abort) begin
               state_d = XS_IDLE;
            end else if (mem_rd_ack) begin
               sbuf_d  = mem_rd_data;
               state_d = (mode_q == XFER_XOR) ? XS_RD_DST : XS_WR;
            end
         end
         XS_RD_DST: begin
            busy        = 1'b1;
            mem_rd      = rd_req(mem_rd_ack);
            mem_rd_addr = dst_elem;
            if (abort) begin
               state_d = XS_IDLE;
            end else if (mem_rd_ack) begin
               dbuf_d  = mem_rd_data;
               state_d = XS_WR;
            end
         end
         XS_WR: begin
            busy        = 1'b1;
            mem_wr_addr = dst_elem;
            mem_wr_data = wr_data;
            if (abort) begin
               state_d = XS_IDLE;
            end else begin
               mem_wr = 1'b1;
               if (mode_q == XFER_XOR) begin
                  coll_d = coll_q | (|(sbuf_q & dbuf_q));
               end
               if (last_elem) begin
                  state_d = XS_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = (mode_q == XFER_FILL) ? XS_WR : XS_RD_SRC;
               end
            end
         end
         XS_DONE: begin
            done    = 1'b1;
            state_d = XS_IDLE;
         end
         default: state_d = XS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= XS_IDLE;
         mode_q  <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         fill_q  <= '0;
         sbuf_q  <= '0;
         dbuf_q  <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         fill_q  <= fill_d;
         sbuf_q  <= sbuf_d;
         dbuf_q  <= dbuf_d;
         coll_q  <= coll_d;
      end
   end

endmodule
